// File: rtl/arith_pipe_vr_pkg.sv
// ============================================================================
//  Module   : arith_pipe_pkg
//  Purpose  : Shared widths, stage-valid type and helpers for arith_pipe_vr.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package arith_pipe_pkg;

   // Number of valid+data stages in the pipe.
   localparam int NUM_STAGES = 3;

   // Occupancy counter width; holds 0..NUM_STAGES.
   localparam int OCC_W = 2;

   // One valid bit per stage, bit 0 = first stage.
   typedef logic [NUM_STAGES-1:0] stage_vld_t;

   // Width of x+y: one carry bit above the operand width, so it never overflows.
   function automatic int SW(input int w);
      return w + 1;
   endfunction

   // Width of (x+y)^2: square of a (W+1)-bit value.
   function automatic int S2W(input int w);
      return 2 * w + 2;
   endfunction

   // Width of x^2 - OFFSET: wraps modulo 2^(2W).
   function automatic int XW(input int w);
      return 2 * w;
   endfunction

   // Count of set stage-valid bits.
   function automatic logic [OCC_W-1:0] popcnt3(input stage_vld_t v);
      return OCC_W'(v[0]) + OCC_W'(v[1]) + OCC_W'(v[2]);
   endfunction

endpackage : arith_pipe_pkg

`default_nettype wire

// File: rtl/arith_pipe_vr_slot.sv
// ============================================================================
//  Module   : pipe_slot
//  Purpose  : One valid/ready pipeline stage (valid bit + data register).
//             Ready toward upstream is combinational: the slot can take a new
//             item when it is empty or when its item leaves this cycle, which
//             lets bubbles collapse without a skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [DW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [DW-1:0] dn_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;
   logic          w_load;

   // The slot advances whenever it is empty or its current item is taken.
   assign up_ready = !r_valid | dn_ready;

   // Data only moves on a real transfer; a flushed offer is not captured.
   assign w_load   = up_valid & up_ready & !flush;

   assign dn_valid = r_valid;
   assign dn_data  = r_data;

   // Valid tracks the advance rule; flush wins over any incoming item.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (up_ready) begin
         r_valid <= up_valid;
      end
   end

   // Data register: cleared on reset, untouched by flush, loads on transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (w_load) begin
         r_data <= up_data;
      end
   end

endmodule : pipe_slot

`default_nettype wire

// File: rtl/arith_pipe_vr.sv
// ============================================================================
//  Module   : arith_pipe_vr
//  Purpose  : 3-stage unsigned arithmetic pipe with valid/ready on both sides.
//             s2  = (x+y)^2              (full 2W+2 width)
//             out = (x^2 - OFFSET) mod 2^(2W)
//             Stage 1 holds {x+y, x}, stage 2 holds {(x+y)^2, x}, stage 3
//             holds {s2, out}; arithmetic sits between slots so both results
//             leave straight from registers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arith_pipe_vr
   import arith_pipe_pkg::*;
#(
   parameter int          W      = 8,
   parameter int unsigned OFFSET = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       x,
   input  logic [W-1:0]       y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*W+1:0]     s2,
   output logic [2*W-1:0]     out,
   output logic [OCC_W-1:0]   occupancy
);

   localparam int c_sw  = SW(W);
   localparam int c_s2w = S2W(W);
   localparam int c_xw  = XW(W);

   // Offset reduced to the result width so the subtraction wraps modulo 2^(2W).
   localparam logic [c_xw-1:0] c_offset = c_xw'(OFFSET);

   localparam int c_d1w = c_sw + W;       // {sum, x}
   localparam int c_d2w = c_s2w + W;      // {square, x}
   localparam int c_d3w = c_s2w + c_xw;   // {s2, out}

   // ---------------------------------------------------------------- stage 1
   logic [c_sw-1:0]  w_sum;
   logic             w_v1;
   logic             w_rdy2;
   logic [c_d1w-1:0] w_s1_data;
   logic [c_sw-1:0]  w_s1_sum;
   logic [W-1:0]     w_s1_x;

   // Zero-extend both operands so the carry lands in the extra bit.
   assign w_sum = c_sw'(x) + c_sw'(y);

   pipe_slot #(
      .DW (c_d1w)
   ) u_slot1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (in_valid),
      .up_ready (in_ready),
      .up_data  ({w_sum, x}),
      .dn_valid (w_v1),
      .dn_ready (w_rdy2),
      .dn_data  (w_s1_data)
   );

   assign {w_s1_sum, w_s1_x} = w_s1_data;

   // ---------------------------------------------------------------- stage 2
   logic [c_s2w-1:0] w_sq;
   logic             w_v2;
   logic             w_rdy3;
   logic [c_d2w-1:0] w_s2_data;
   logic [c_s2w-1:0] w_s2_sq;
   logic [W-1:0]     w_s2_x;

   // (W+1)-bit square fits exactly in 2W+2 bits; no truncation occurs.
   assign w_sq = c_s2w'(w_s1_sum) * c_s2w'(w_s1_sum);

   pipe_slot #(
      .DW (c_d2w)
   ) u_slot2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (w_v1),
      .up_ready (w_rdy2),
      .up_data  ({w_sq, w_s1_x}),
      .dn_valid (w_v2),
      .dn_ready (w_rdy3),
      .dn_data  (w_s2_data)
   );

   assign {w_s2_sq, w_s2_x} = w_s2_data;

   // ---------------------------------------------------------------- stage 3
   logic [c_xw-1:0]  w_xsq;
   logic [c_xw-1:0]  w_res;
   logic [c_d3w-1:0] w_s3_data;

   // x^2 fits in 2W bits; subtracting the offset wraps (x=0, OFFSET=1 -> all ones).
   assign w_xsq = c_xw'(w_s2_x) * c_xw'(w_s2_x);
   assign w_res = w_xsq - c_offset;

   pipe_slot #(
      .DW (c_d3w)
   ) u_slot3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (w_v2),
      .up_ready (w_rdy3),
      .up_data  ({w_s2_sq, w_res}),
      .dn_valid (out_valid),
      .dn_ready (out_ready),
      .dn_data  (w_s3_data)
   );

   assign {s2, out} = w_s3_data;

   // ------------------------------------------------------------- occupancy
   stage_vld_t w_vld;

   // Sum of the registered stage valids, so it changes only on clock edges.
   assign w_vld     = {out_valid, w_v2, w_v1};
   assign occupancy = popcnt3(w_vld);

endmodule : arith_pipe_vr

`default_nettype wire

// File: tb/tb_arith_pipe_vr.sv
// ============================================================================
//  Module   : tb_arith_pipe_vr
//  Purpose  : Scoreboard bench for arith_pipe_vr (W=8). A main instance with
//             OFFSET=1 and a second with OFFSET=0 share every input.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arith_pipe_vr;

   typedef struct {
      logic [17:0] s2;
      logic [15:0] o1;
      logic [15:0] o0;
      int          stamp;
   } exp_t;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  x         = '0;
   logic [7:0]  y         = '0;

   logic        in_ready,  out_valid;
   logic [17:0] s2;
   logic [15:0] out;
   logic [1:0]  occupancy;

   logic        in_ready0, out_valid0;
   logic [17:0] s2_0;
   logic [15:0] out_0;
   logic [1:0]  occ0;

   // Expected results for whatever is currently offered on x/y.
   logic [17:0] e_s2 = '0;
   logic [15:0] e_o1 = '0;
   logic [15:0] e_o0 = '0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   chk_lat  = 1'b0;
   exp_t q[$];

   arith_pipe_vr #(.W(8), .OFFSET(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s2        (s2),
      .out       (out),
      .occupancy (occupancy)
   );

   arith_pipe_vr #(.W(8), .OFFSET(0)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .x         (x),
      .y         (y),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .s2        (s2_0),
      .out       (out_0),
      .occupancy (occ0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] m_s2(input logic [7:0] a, input logic [7:0] b);
      logic [17:0] s;
      s = 18'(a) + 18'(b);
      return s * s;
   endfunction

   function automatic logic [15:0] m_out(input logic [7:0] a, input logic [15:0] off);
      logic [15:0] p;
      p = 16'(a) * 16'(a);
      return p - off;
   endfunction

   task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                         input logic [17:0] es2, input logic [15:0] eo1,
                         input logic [15:0] eo0);
      x = a; y = b; e_s2 = es2; e_o1 = eo1; e_o0 = eo0;
      in_valid = 1'b1;
   endtask

   task automatic set_rnd();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      set_in(a, b, m_s2(a, b), m_out(a, 16'd1), m_out(a, 16'd0));
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
      #1;
   endtask

   // Monitor: occupancy against the in-flight count, head of queue against the
   // presented result, pop on output transfer, push on accepted input.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         q.delete();
      end else begin
         chk("occupancy", 64'(occupancy), 64'(q.size()));
         chk("occupancy_off0", 64'(occ0), 64'(q.size()));
         if (out_valid) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_out s2=%0d out=%0d expected=no_item", s2, out);
            end else begin
               chk("s2", 64'(s2), 64'(q[0].s2));
               chk("out", 64'(out), 64'(q[0].o1));
               chk("out_valid_off0", 64'(out_valid0), 64'd1);
               chk("s2_off0", 64'(s2_0), 64'(q[0].s2));
               chk("out_off0", 64'(out_0), 64'(q[0].o0));
               if (out_ready) begin
                  if (chk_lat) chk("latency", 64'(cyc - q[0].stamp), 64'd3);
                  void'(q.pop_front());
               end
            end
         end
         if (flush) q.delete();
         else if (in_valid && in_ready) q.push_back('{e_s2, e_o1, e_o0, cyc});
      end
   end

   initial begin
      // ---- reset state
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_s2", 64'(s2), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // ---- streaming, back-to-back, with latency check
      @(posedge clk); #1;
      out_ready = 1'b1;
      chk_lat   = 1'b1;
      set_in(8'd3, 8'd4, 18'd49, 16'd8, 16'd9);
      @(posedge clk); #1;
      set_in(8'd255, 8'd255, 18'd260100, 16'd65024, 16'd65025);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_not_yet", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("stream1_valid", 64'(out_valid), 64'd1);
      chk("stream1_s2", 64'(s2), 64'd49);
      chk("stream1_out", 64'(out), 64'd8);
      @(negedge clk);
      chk("stream2_valid", 64'(out_valid), 64'd1);
      chk("stream2_s2", 64'(s2), 64'd260100);
      chk("stream2_out", 64'(out), 64'd65024);
      @(negedge clk);
      chk("stream_empty", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk_lat = 1'b0;

      // ---- wrap: x=0 gives all ones with OFFSET=1, zero with OFFSET=0
      set_in(8'd0, 8'd0, 18'd0, 16'hFFFF, 16'd0);
      @(posedge clk); #1 in_valid = 1'b0;
      drain();

      // ---- reset asserted with items in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_rnd();
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_s2", 64'(s2), 64'd0);
      chk("midrst_out", 64'(out), 64'd0);
      chk("midrst_occupancy", 64'(occupancy), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // ---- backpressure: four offered, three accepted, then in-order drain
      out_ready = 1'b0;
      set_in(8'd10, 8'd20, 18'd900, 16'd99, 16'd100);
      @(posedge clk); #1;
      set_in(8'd1, 8'd2, 18'd9, 16'd0, 16'd1);
      @(posedge clk); #1;
      set_in(8'd100, 8'd50, 18'd22500, 16'd9999, 16'd10000);
      @(posedge clk); #1;
      set_in(8'd200, 8'd7, 18'd42849, 16'd39999, 16'd40000);
      repeat (3) begin
         @(negedge clk);
         chk("full_in_ready", 64'(in_ready), 64'd0);
         chk("full_in_ready_off0", 64'(in_ready0), 64'd0);
         chk("full_occupancy", 64'(occupancy), 64'd3);
         chk("full_hold_s2", 64'(s2), 64'd900);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("full_pass_in_ready", 64'(in_ready), 64'd1);
      chk("full_pass_occupancy", 64'(occupancy), 64'd3);
      @(posedge clk); #1 in_valid = 1'b0;
      drain();

      // ---- bubbles with random back-pressure
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) set_rnd();
         else            in_valid = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // ---- flush a full pipe with a same-cycle offer
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_rnd();
         @(posedge clk); #1;
      end
      set_rnd();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_pre_occupancy", 64'(occupancy), 64'd3);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      set_in(8'd7, 8'd9, 18'd256, 16'd48, 16'd49);
      @(posedge clk); #1 in_valid = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_arith_pipe_vr

`default_nettype wire
